id_fwd_stage: RTL

Parametrised instruction-decode pipeline stage for the 5-stage MIPS-style CPU: holds the IF/ID pipeline register, a NREG×XLEN register file, and operand selection with data-hazard handling. Sits between the fetch stage and the EX stage; the external control unit decodes `id_inst` combinationally and returns source-usage flags. Adds over the previous decode stage: valid/stall/flush handshake, load-use interlock, EX/MEM/WB operand forwarding, and a stall counter.

---
 rtl/id_fwd_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: IF/ID register, register file, operand resolution with hazard interlock.
// Define ID_FWD_EN to enable EX/MEM forwarding (only load-use stalls); otherwise ID stalls until producers reach WB.
module id_fwd_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc4,
    output logic            id_ready,
    input  logic            flush,
    input  logic            use_rs,
    input  logic            use_rt,
    input  logic            sext,
    input  logic            ex_valid,
    input  logic            ex_wreg,
    input  logic            ex_m2reg,
    input  logic [4:0]      ex_destR,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_valid,
    input  logic            mem_wreg,
    input  logic [4:0]      mem_destR,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_wreg,
    input  logic [4:0]      wb_destR,
    input  logic [XLEN-1:0] wb_dest,
    output logic            id_valid,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc4,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] id_inA,
    output logic [XLEN-1:0] id_inB,
    output logic [XLEN-1:0] id_imm,
    output logic            id_stall,
    output logic [31:0]     stall_cnt,
    input  logic [4:0]      which_reg,
    output logic [XLEN-1:0] reg_content
);
    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic            v_q;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc4_q;
    logic [31:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] rf_q [NREG];

    logic [AW-1:0]   rs_idx, rt_idx, wb_idx;
    logic            rs_used, rt_used;
    logic            ex_rs, ex_rt, mem_rs, mem_rt;
    logic [XLEN-1:0] rf_rs, rf_rt;
    logic            stall;

    assign rs_idx  = inst_q[21 +: AW];
    assign rt_idx  = inst_q[16 +: AW];
    assign wb_idx  = wb_destR[AW-1:0];
    assign rs_used = use_rs & (rs_idx != '0);
    assign rt_used = use_rt & (rt_idx != '0);

    assign ex_rs  = rs_used & ex_valid & ex_wreg & (ex_destR[AW-1:0] == rs_idx);
    assign ex_rt  = rt_used & ex_valid & ex_wreg & (ex_destR[AW-1:0] == rt_idx);
    assign mem_rs = rs_used & mem_valid & mem_wreg & (mem_destR[AW-1:0] == rs_idx);
    assign mem_rt = rt_used & mem_valid & mem_wreg & (mem_destR[AW-1:0] == rt_idx);

    // Register-file read with WB write-through; index 0 is hard-wired to zero.
    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (rs_idx != '0)
            rf_rs = (wb_wreg && wb_idx == rs_idx) ? wb_dest : rf_q[rs_idx];
        if (rt_idx != '0)
            rf_rt = (wb_wreg && wb_idx == rt_idx) ? wb_dest : rf_q[rt_idx];
    end

`ifdef ID_FWD_EN
    always_comb begin
        id_inA = ex_rs ? ex_result : (mem_rs ? mem_result : rf_rs);
        id_inB = ex_rt ? ex_result : (mem_rt ? mem_result : rf_rt);
        stall  = v_q & ex_m2reg & (ex_rs | ex_rt);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_m2reg, ex_result, mem_result};

    always_comb begin
        id_inA = rf_rs;
        id_inB = rf_rt;
        stall  = v_q & (ex_rs | ex_rt | mem_rs | mem_rt);
    end
`endif

    assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= 1'b0;
            inst_q <= '0;
            pc4_q  <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wb_wreg && wb_idx != '0) rf_q[wb_idx] <= wb_dest;
            // Flush outranks the interlock: the killed slot must not be held.
            if (flush) begin
                v_q <= 1'b0;
            end else if (!stall) begin
                v_q    <= if_valid;
                inst_q <= if_inst;
                pc4_q  <= if_pc4;
            end
        end
    end

    assign id_stall    = stall;
    assign id_ready    = ~stall;
    assign id_valid    = v_q & ~stall & ~flush;
    assign id_inst     = inst_q;
    assign id_pc4      = pc4_q;
    assign rs          = inst_q[25:21];
    assign rt          = inst_q[20:16];
    assign rd          = inst_q[15:11];
    assign id_imm      = sext ? {{(XLEN-16){inst_q[15]}}, inst_q[15:0]}
                              : {{(XLEN-16){1'b0}}, inst_q[15:0]};
    assign stall_cnt   = cnt_q;
    assign reg_content = rf_q[which_reg[AW-1:0]];

endmodule
